// File: rtl/id_ex_stage_pkg.sv
// Shared encodings for the ID/EX stage: ALU classes, opcodes and the control-bundle layout.
// The control bundle is ordered MSB first: reg_dst .. ext_op, then alu_op in the low two bits.
package id_ex_stage_pkg;

   typedef enum logic [1:0] {
      ALUOP_RTYPE = 2'b00,
      ALUOP_OR    = 2'b01,
      ALUOP_ADD   = 2'b10,
      ALUOP_SUB   = 2'b11
   } alu_op_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef struct packed {
      logic    reg_dst;
      logic    alu_src;
      logic    mem_to_reg;
      logic    reg_write;
      logic    mem_write;
      logic    branch;
      logic    jump;
      logic    ext_op;
      alu_op_e alu_op;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   // An empty ID slot must never carry live control bits into EX.
   function automatic ctrl_t gate_ctrl(input ctrl_t c, input logic valid);
      return valid ? c : CTRL_BUBBLE;
   endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use detector: a load in EX whose destination is read by the ID instruction.
module load_use_detect
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned RA_W = 5
) (
   input  logic            id_valid,
   input  logic            id_jump,
   input  logic            id_reg_dst,
   input  logic            id_mem_write,
   input  logic            id_branch,
   input  logic [RA_W-1:0] id_rs,
   input  logic [RA_W-1:0] id_rt,
   input  logic            ex_valid,
   input  logic            ex_mem_to_reg,
   input  logic            ex_reg_write,
   input  logic [RA_W-1:0] ex_rt,
   output logic            hazard
);

   logic uses_rs;
   logic uses_rt;
   logic ex_is_load;

   assign uses_rs = ~id_jump;
   // Only R-type, sw and beq read rt as a source; ori and lw write it.
   assign uses_rt = id_reg_dst | id_mem_write | id_branch;

   assign ex_is_load = ex_valid & ex_mem_to_reg & ex_reg_write & (ex_rt != '0);

   assign hazard = id_valid & ex_is_load &
                   ((uses_rs & (ex_rt == id_rs)) | (uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, branch/jump squash and saturating
// stall/flush performance counters.
module id_ex_stage
   import id_ex_stage_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RA_W   = 5,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic              id_reg_dst,
   input  logic              id_alu_src,
   input  logic              id_mem_to_reg,
   input  logic              id_reg_write,
   input  logic              id_mem_write,
   input  logic              id_branch,
   input  logic              id_jump,
   input  logic              id_ext_op,
   input  logic [1:0]        id_alu_op,
   input  logic [DATA_W-1:0] id_pc4,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [RA_W-1:0]   id_rs,
   input  logic [RA_W-1:0]   id_rt,
   input  logic [RA_W-1:0]   id_rd,
   input  logic [5:0]        id_funct,
   input  logic              ex_flush,
   output logic              ex_valid,
   output logic              ex_reg_dst,
   output logic              ex_alu_src,
   output logic              ex_mem_to_reg,
   output logic              ex_reg_write,
   output logic              ex_mem_write,
   output logic              ex_branch,
   output logic              ex_jump,
   output logic              ex_ext_op,
   output logic [1:0]        ex_alu_op,
   output logic [DATA_W-1:0] ex_pc4,
   output logic [DATA_W-1:0] ex_rs_data,
   output logic [DATA_W-1:0] ex_rt_data,
   output logic [DATA_W-1:0] ex_imm,
   output logic [RA_W-1:0]   ex_rs,
   output logic [RA_W-1:0]   ex_rt,
   output logic [RA_W-1:0]   ex_rd,
   output logic [5:0]        ex_funct,
   output logic              stall,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   ctrl_t id_ctrl;
   ctrl_t ex_ctrl;
   logic  hazard;

   assign id_ctrl = '{
      reg_dst:    id_reg_dst,
      alu_src:    id_alu_src,
      mem_to_reg: id_mem_to_reg,
      reg_write:  id_reg_write,
      mem_write:  id_mem_write,
      branch:     id_branch,
      jump:       id_jump,
      ext_op:     id_ext_op,
      alu_op:     alu_op_e'(id_alu_op)
   };

   load_use_detect #(
      .RA_W (RA_W)
   ) u_load_use_detect (
      .id_valid      (id_valid),
      .id_jump       (id_jump),
      .id_reg_dst    (id_reg_dst),
      .id_mem_write  (id_mem_write),
      .id_branch     (id_branch),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .ex_valid      (ex_valid),
      .ex_mem_to_reg (ex_ctrl.mem_to_reg),
      .ex_reg_write  (ex_ctrl.reg_write),
      .ex_rt         (ex_rt),
      .hazard        (hazard)
   );

   // A flush squashes the ID instruction anyway, so it overrides the stall.
   assign stall = hazard & ~ex_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid   <= 1'b0;
         ex_ctrl    <= CTRL_BUBBLE;
         ex_pc4     <= '0;
         ex_rs_data <= '0;
         ex_rt_data <= '0;
         ex_imm     <= '0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rd      <= '0;
         ex_funct   <= '0;
      end else if (ex_flush || hazard) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= CTRL_BUBBLE;
      end else begin
         ex_valid   <= id_valid;
         ex_ctrl    <= gate_ctrl(id_ctrl, id_valid);
         ex_pc4     <= id_pc4;
         ex_rs_data <= id_rs_data;
         ex_rt_data <= id_rt_data;
         ex_imm     <= id_imm;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rd      <= id_rd;
         ex_funct   <= id_funct;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (ex_flush && id_valid && (flush_cnt != '1)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

   assign ex_reg_dst    = ex_ctrl.reg_dst;
   assign ex_alu_src    = ex_ctrl.alu_src;
   assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
   assign ex_reg_write  = ex_ctrl.reg_write;
   assign ex_mem_write  = ex_ctrl.mem_write;
   assign ex_branch     = ex_ctrl.branch;
   assign ex_jump       = ex_ctrl.jump;
   assign ex_ext_op     = ex_ctrl.ext_op;
   assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode control unit.
- Registers the decoded control bits (RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, Branch, Jump, ExtOp, ALUOp) together with the operands, register specifiers and PC+4 for the EX stage.
- Contains the load-use hazard detector. On a hazard it stalls PC and IF/ID and inserts a bubble. It also squashes the ID instruction when EX resolves a taken branch or a jump.
- Keeps saturating performance counters for stalls and flushes.

Parameters:
- DATA_W, 32, operand / PC width
- RA_W, 5, register specifier width
- CNT_W, 16, width of the stall and flush counters

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write, id_mem_write, id_branch, id_jump, id_ext_op  in  1 each  control bits from the control unit
- id_alu_op  in  2  ALU class from the control unit: 00 R-type, 01 or, 10 add, 11 sub
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DATA_W  register-file read data
- id_imm  in  DATA_W  extended immediate
- id_rs, id_rt, id_rd  in  RA_W  register specifiers
- id_funct  in  6  funct field
- ex_flush  in  1  taken branch or jump resolved in EX this cycle
- ex_valid  out  1  registered valid
- ex_reg_dst … ex_ext_op, ex_alu_op  out  1 / 2  registered copies of the control inputs
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  out  DATA_W  registered operands
- ex_rs, ex_rt, ex_rd  out  RA_W  registered specifiers
- ex_funct  out  6  registered funct field
- stall  out  1  combinational; holds PC and IF/ID this cycle
- stall_cnt  out  CNT_W  saturating count of stall cycles
- flush_cnt  out  CNT_W  saturating count of flushed cycles

Behaviour:
- Reset (asynchronous, active-high): every registered output goes to 0, including ex_valid, all control bits, ex_alu_op = 00, data, specifiers and both counters. stall is 0 while rst is high.
- Latency: 1 cycle from ID inputs to ex_* outputs.
- uses_rs is !id_jump.
- uses_rt is id_reg_dst | id_mem_write | id_branch (R-type, sw, beq). ori and lw do not use rt.
- hazard is true when all of the following hold:
  - id_valid, ex_valid, ex_mem_to_reg and ex_reg_write are all 1;
  - ex_rt != 0;
  - (uses_rs & ex_rt == id_rs) or (uses_rt & ex_rt == id_rt).
- stall = hazard & !ex_flush. Pure combinational, with no dependence on stall from the previous cycle.
- Each clock edge, in priority order:
  - ex_flush = 1: load a bubble (ex_valid and all control bits 0, ex_alu_op = 00; data and specifier fields are don't-care, implement as hold). Increment flush_cnt when id_valid = 1.
  - else hazard: load a bubble and increment stall_cnt.
  - else: capture all id_* inputs. ex_valid takes id_valid. When id_valid = 0, all captured control bits are forced to 0.
- A bubble never asserts reg_write, mem_write, branch or jump. Downstream stages rely on this.
- A load followed by a dependent instruction produces exactly one stall cycle. On the next cycle ex_valid is 0, so the hazard clears.
- Hazard on a $0 destination is suppressed (ex_rt = 0 never stalls).
- Counters saturate at all-ones and never wrap.
- Flush and hazard in the same cycle: the flush wins, stall = 0, and stall_cnt is unchanged.
- Reset asserted mid-stall: stall drops immediately, because ex_valid is cleared asynchronously.

Decomposition:
- Shared package holds:
  - ALUOp encodings ALUOP_RTYPE = 00, ALUOP_OR = 01, ALUOP_ADD = 10, ALUOP_SUB = 11;
  - opcode constants (R-type 000000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010);
  - the control-bundle bit order.
- One natural sub-module: load_use_detect. It is combinational and produces hazard from the ex_* and id_* specifiers and control bits.
- Counters and registers stay in id_ex_stage.

Test Plan:
- Reset: drive rst = 1 mid-stream with ex_mem_to_reg = 1 held -> all outputs 0 and stall = 0 within the same cycle; counters read 0.
- Pass-through: R-type add (reg_dst = 1, reg_write = 1, alu_op = 00, rs = 8, rt = 9, rd = 10) -> next cycle ex_* match exactly; stall = 0.
- Load-use: lw $9 (rt = 9) then add using rs = 9 -> one cycle with stall = 1, then ex_valid = 0 bubble, then the add is captured; stall_cnt = 1.
- No false stall:
  - lw $9 then ori rt = 9, rs = 4 -> stall = 0.
  - lw $0 then add rs = 0 -> stall = 0.
  - sw reading rt = 9 after lw $9 -> stall = 1.
- Flush priority: hazard condition and ex_flush = 1 in the same cycle -> stall = 0, bubble loaded, flush_cnt = 1, stall_cnt unchanged.
- Saturation: with CNT_W = 4, force 20 stall cycles -> stall_cnt holds 15.
